// File: rtl/softmax_scheduler_pkg.sv
// Shared definitions for the softmax scheduler slice.
//   state_t      : scheduler FSM states
//   LANES        : datapath lane count (operands issued per group)
//   MAG_W        : width of the zero-extended magnitude fed to float_gt
//   float_gt     : sign-magnitude "a beats b" compare for the running max
//   lane_is_pad  : a lane position at or beyond the vector length is padded
//                  with the vector maximum
package softmax_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  localparam int unsigned LANES = 4;
  localparam int unsigned MAG_W = 63;

  // Positive beats negative; among positives the larger magnitude wins, among
  // negatives the smaller one. +0 and -0 compare equal, so the current value
  // is kept. NaN encodings are ordered like any other bit pattern.
  function automatic logic float_gt(input logic             a_sign,
                                    input logic [MAG_W-1:0] a_mag,
                                    input logic             b_sign,
                                    input logic [MAG_W-1:0] b_mag);
    logic gt;
    gt = 1'b0;
    if (a_mag == '0 && b_mag == '0) begin
      gt = 1'b0;
    end else if (a_sign != b_sign) begin
      gt = !a_sign;
    end else if (!a_sign) begin
      gt = a_mag > b_mag;
    end else begin
      gt = a_mag < b_mag;
    end
    return gt;
  endfunction

  function automatic logic lane_is_pad(input int unsigned pos,
                                       input int unsigned len);
    return pos >= len;
  endfunction

endpackage

// File: rtl/softmax_max_tracker.sv
// Running-maximum register for the scheduler's input vector.
//   clk, reset : clock, asynchronous active-low reset
//   first      : the current accept is the first element of a vector
//   load       : an element is accepted this cycle
//   din        : accepted element
//   max_val    : running maximum (sign-magnitude float ordering)
module softmax_max_tracker
  import softmax_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned E          = 8,
  parameter int unsigned M          = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  first,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] max_val
);

  localparam int unsigned SIGN_BIT = E + M;

  logic new_wins;

  always_comb begin
    new_wins = float_gt(din[SIGN_BIT], MAG_W'(din[SIGN_BIT-1:0]),
                        max_val[SIGN_BIT], MAG_W'(max_val[SIGN_BIT-1:0]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val <= '0;
    end else if (load && (first || new_wins)) begin
      max_val <= din;
    end
  end

endmodule

// File: rtl/softmax_scheduler.sv
// Buffers a float vector, issues it to a 4-lane softmax datapath one group at
// a time, writes lane results back in place, and streams them out.
//   clk, reset                   : clock, asynchronous active-low reset
//   in_valid/in_ready/in_last    : input element handshake, in_data element
//   dp_enable                    : one-cycle group start pulse
//   dp_in1..dp_in4, dp_max       : lane operands and vector maximum
//   dp_ready, dp_out1..dp_out4   : datapath result flag and lane results
//   out_valid/out_ready/out_last : result handshake, out_data element
//   busy                         : high outside IDLE
//   err_len, err_timeout         : one-cycle pulses (truncation / no result)
// err_len is high in the cycle after the truncating accept; err_timeout is
// high in the first IDLE cycle after the vector is abandoned.
module softmax_scheduler
  import softmax_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned E          = 8,
  parameter int unsigned M          = 23,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  dp_enable,
  output logic [DATA_WIDTH-1:0] dp_in1,
  output logic [DATA_WIDTH-1:0] dp_in2,
  output logic [DATA_WIDTH-1:0] dp_in3,
  output logic [DATA_WIDTH-1:0] dp_in4,
  output logic [DATA_WIDTH-1:0] dp_max,
  input  logic                  dp_ready,
  input  logic [DATA_WIDTH-1:0] dp_out1,
  input  logic [DATA_WIDTH-1:0] dp_out2,
  input  logic [DATA_WIDTH-1:0] dp_out3,
  input  logic [DATA_WIDTH-1:0] dp_out4,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  err_len,
  output logic                  err_timeout
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = CW + 2;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] buffer [MAX_LEN];
  logic [CW-1:0]         count;
  logic [CW-1:0]         grp;
  logic [CW-1:0]         rd_idx;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] max_val;

  logic [PW-1:0]         lane_pos   [LANES];
  logic [DATA_WIDTH-1:0] lane_word  [LANES];
  logic [DATA_WIDTH-1:0] dp_res     [LANES];
  logic [LANES-1:0]      lane_valid;
  logic [PW-1:0]         next_base;

  logic in_fire, out_fire, len_full, capture, timed_out, last_group;
  logic operands_on, first_elem;

  softmax_max_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .E         (E),
    .M         (M)
  ) u_max (
    .clk    (clk),
    .reset  (reset),
    .first  (first_elem),
    .load   (in_fire),
    .din    (in_data),
    .max_val(max_val)
  );

  always_comb begin
    first_elem = (state == S_IDLE);
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    len_full   = (count == CW'(MAX_LEN - 1));
    capture    = (state == S_WAIT) && dp_ready;
    timed_out  = (state == S_WAIT) && !dp_ready && (tcnt == TW'(TIMEOUT - 1));
    next_base  = {grp + CW'(1), 2'b00};
    last_group = (next_base >= {2'b00, count});
  end

  always_comb begin
    dp_res[0] = dp_out1;
    dp_res[1] = dp_out2;
    dp_res[2] = dp_out3;
    dp_res[3] = dp_out4;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_pos[i]   = {grp, 2'b00} + PW'(i);
      lane_valid[i] = !lane_is_pad(32'(lane_pos[i]), 32'(count));
      lane_word[i]  = lane_valid[i] ? buffer[lane_pos[i][AW-1:0]] : max_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    dp_enable   = 1'b0;
    operands_on = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    unique case (state)
      S_IDLE: begin
        in_ready = reset;
        if (in_valid) begin
          state_next = in_last ? S_ISSUE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = reset;
        if (in_valid && (in_last || len_full)) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dp_enable   = 1'b1;
        operands_on = 1'b1;
        state_next  = S_WAIT;
      end
      S_WAIT: begin
        operands_on = 1'b1;
        if (dp_ready) begin
          state_next = last_group ? S_DRAIN : S_ISSUE;
        end else if (timed_out) begin
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = buffer[rd_idx[AW-1:0]];
        out_last  = (rd_idx == count - CW'(1));
        if (out_ready && out_last) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    dp_in1 = operands_on ? lane_word[0] : '0;
    dp_in2 = operands_on ? lane_word[1] : '0;
    dp_in3 = operands_on ? lane_word[2] : '0;
    dp_in4 = operands_on ? lane_word[3] : '0;
    dp_max = operands_on ? max_val : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      grp         <= '0;
      rd_idx      <= '0;
      tcnt        <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_len     <= in_fire && len_full && !in_last;
      err_timeout <= timed_out;
      if (in_fire) begin
        count <= count + CW'(1);
      end
      if (state == S_ISSUE) begin
        tcnt <= '0;
      end else if (state == S_WAIT) begin
        tcnt <= tcnt + TW'(1);
      end
      if (capture) begin
        grp    <= grp + CW'(1);
        rd_idx <= '0;
      end
      if (out_fire && !out_last) begin
        rd_idx <= rd_idx + CW'(1);
      end
      if (timed_out || (out_fire && out_last)) begin
        count <= '0;
        grp   <= '0;
      end
    end
  end

  // Results overwrite their source slots, so the same storage serves load and drain.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buffer[count[AW-1:0]] <= in_data;
    end
    if (capture) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_valid[i]) begin
          buffer[lane_pos[i][AW-1:0]] <= dp_res[i];
        end
      end
    end
  end

endmodule

// File: doc/softmax_scheduler.md
SOFTMAX_SCHEDULER -- requirements
Module: softmax_scheduler

Interface
REQ-001 Parameters, one per line: DATA_WIDTH, 32, float word width; E, 8, exponent bits; M, 23, mantissa bits; MAX_LEN, 16, max vector length (multiple of 4); TIMEOUT, 255, max wait cycles per group.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 in_valid/in_ready/in_last  input/output/input  1 each  input element handshake; in_last marks final element.
REQ-005 in_data  input  DATA_WIDTH  float input element.
REQ-006 dp_enable  output  1  one-cycle start pulse to the 4-lane softmax datapath.
REQ-007 dp_in1..dp_in4, dp_max  output  DATA_WIDTH each  lane operands and vector maximum.
REQ-008 dp_ready  input  1  datapath result-ready flag; dp_out1..dp_out4  input  DATA_WIDTH each  lane results.
REQ-009 out_valid/out_ready/out_last  output/input/output  1 each  result stream handshake.
REQ-010 out_data  output  DATA_WIDTH  result element; busy  output  1  high outside IDLE; err_len, err_timeout  output  1 each  one-cycle error pulses.

Function
REQ-011 States: IDLE, LOAD, ISSUE, WAIT, DRAIN.
REQ-012 in_ready is high in IDLE and LOAD only; each in_valid&&in_ready writes buffer[count] and increments count (width clog2(MAX_LEN)+1).
REQ-013 IDLE -> LOAD on first accept; the first element initialises the running max.
REQ-014 Running max uses sign-magnitude ordering: positive beats negative; larger magnitude wins among positives, smaller among negatives; +0 and -0 are equal (keep current); NaN is not specially handled.
REQ-015 Accept with in_last, or the MAX_LEN-th accept -> ISSUE next cycle; MAX_LEN-th accept without in_last pulses err_len for one cycle and the vector is truncated to MAX_LEN.
REQ-016 groups = ceil(count/4); group g drives lanes buffer[4g..4g+3]; lanes at index >= count are driven with the max value.
REQ-017 ISSUE asserts dp_enable for exactly one cycle with operands and dp_max stable, then -> WAIT; operands stay stable until capture.
REQ-018 WAIT: the first cycle with dp_ready high captures dp_out1..4 into buffer[4g..4g+3] (valid lanes only), increments g, -> ISSUE if groups remain, else DRAIN.
REQ-019 dp_ready is ignored in the ISSUE cycle and in the cycle dp_enable is high.
REQ-020 WAIT counts cycles; reaching TIMEOUT without dp_ready pulses err_timeout, abandons the vector, -> IDLE with count and g cleared.
REQ-021 DRAIN presents buffer[0..count-1] in order; out_valid high; advance on out_valid&&out_ready; out_data/out_last held stable while out_ready low.
REQ-022 out_last is high only with element count-1; its accept -> IDLE next cycle; a new vector may load from that cycle.
REQ-023 Latency: first dp_enable occurs one cycle after the final input accept; out_valid rises one cycle after the last capture.

Reset
REQ-024 On reset low, all outputs go to 0 immediately (in_ready 0, dp_enable 0, out_valid 0, busy 0, errors 0) and state = IDLE.
REQ-025 After reset release, in_ready = 1 from the first clock edge.
REQ-026 Reset mid-operation discards the buffer, count, group index and timeout counter; no partial output follows.

Structure
REQ-027 The shared package holds the state enumeration, the float-max compare function, and the pad constant rule.
REQ-028 One sub-module, softmax_max_tracker, implements the running-max register and comparator; buffer and FSM live in the top.

Verification
REQ-029 Load 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (last on 4th) -> one dp_enable with dp_max = 0x40800000 and lanes in order; a model result returned 3 cycles later is drained as 4 elements with out_last on the 4th.
REQ-030 6-element vector with max 0xC0000000 (all negative, -2.0 largest) -> 2 groups; lanes 3 and 4 of group 2 are driven with 0xC0000000; exactly 6 outputs.
REQ-031 Send 16 elements with no in_last -> err_len pulses on the 16th accept, in_ready drops, 4 groups issued.
REQ-032 Model never raises dp_ready -> err_timeout pulses after 255 WAIT cycles, then IDLE with in_ready = 1 and no out_valid.
REQ-033 Hold out_ready low 5 cycles mid-drain -> out_data/out_last stable, no element lost or duplicated.
REQ-034 Assert reset during WAIT -> all outputs 0 asynchronously; after release, a fresh 1-element vector (0xBF800000, last) yields dp_max = 0xBF800000 and exactly one output.
